// File: rtl/mul_pkg.sv
// Shared types for the shift-add multiplier: opcodes, per-request sideband, register-index width.
package mul_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef struct packed {
    mul_op_e          op;
    logic             neg;
    logic [REG_W-1:0] rd;
    logic             valid;
  } mul_sb_t;

endpackage

// File: rtl/mul_post_fifo.sv
// DEPTH-entry in-order FIFO with synchronous flush; head is read combinationally from storage.
// Writes while full and pops while empty are dropped; flush overrides both in the same cycle.
module mul_post_fifo #(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mul_post.sv
// Multiplier writeback stage: sideband delay line, sign fix, lo/hi select, result FIFO, issue credits.
// Result enters FIFO STAGES cycles after issue; credits stall issue so the FIFO never overflows. MUL_POST_CHECK_EN adds err_o.
module mul_post
  import mul_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [1:0]        issue_op_i,
  input  logic              issue_neg_i,
  input  logic [REG_W-1:0]  issue_rd_i,
  input  logic              pipe_ready_i,
  input  logic [2*XLEN:0]   pipe_acc_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [REG_W-1:0]  wb_rd_o
`ifdef MUL_POST_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned FW = XLEN + REG_W;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  mul_sb_t           sb_q [STAGES];
  mul_sb_t           sb_d [STAGES];
  mul_sb_t           tail;
  logic [CW-1:0]     credit_q, credit_d;
  logic              issue_acc, wb_pop;
  logic              fifo_full, fifo_empty;
  logic [PW-1:0]     prod, res;
  logic [XLEN-1:0]   wr_data;
  logic [FW-1:0]     fifo_head;
  logic              unused_acc_msb;

  assign tail          = sb_q[STAGES-1];
  assign issue_ready_o = (credit_q != '0);
  assign issue_acc     = issue_valid_i && issue_ready_o;
  assign wb_valid_o    = !fifo_empty;
  assign wb_pop        = wb_valid_o && wb_ready_i;
  assign unused_acc_msb = pipe_acc_i[PW];

  always_comb begin
    sb_d    = sb_q;
    sb_d[0] = '{op: mul_op_e'(issue_op_i), neg: issue_neg_i, rd: issue_rd_i, valid: issue_acc};
    for (int i = 1; i < int'(STAGES); i++) sb_d[i] = sb_q[i-1];
    if (flush_i) begin
      for (int i = 0; i < int'(STAGES); i++) sb_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(STAGES); i++) sb_q[i] <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // The cell chain produces an unsigned magnitude; negate it here when the true product is negative.
  always_comb begin
    prod    = pipe_acc_i[PW-1:0];
    res     = tail.neg ? (~prod + PW'(1)) : prod;
    wr_data = (tail.op == OP_MUL) ? res[XLEN-1:0] : res[PW-1:XLEN];
  end

  mul_post_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (tail.valid),
    .data_i  ({wr_data, tail.rd}),
    .pop_i   (wb_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wb_data_o = fifo_head[FW-1:REG_W];
  assign wb_rd_o   = fifo_head[REG_W-1:0];

  always_comb begin
    credit_d = credit_q;
    if (flush_i) begin
      credit_d = CW'(DEPTH);
    end else if (issue_acc && !wb_pop) begin
      credit_d = credit_q - CW'(1);
    end else if (wb_pop && !issue_acc) begin
      credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) credit_q <= CW'(DEPTH);
    else         credit_q <= credit_d;
  end

`ifdef MUL_POST_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((pipe_ready_i != tail.valid) || (tail.valid && fifo_full)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_pipe_ready;
  assign unused_pipe_ready = pipe_ready_i ^ fifo_full;
`endif

endmodule

// File: tb/tb_mul_post.sv
// Scoreboard bench for mul_post: models the cell chain timing, credits and FIFO occupancy at transaction level.
module tb_mul_post;

  localparam int XLEN   = 32;
  localparam int STAGES = 32;
  localparam int DEPTH  = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [1:0]  issue_op_i;
  logic        issue_neg_i;
  logic [4:0]  issue_rd_i;
  logic        pipe_ready_i;
  logic [64:0] pipe_acc_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
`ifdef MUL_POST_CHECK_EN
  logic        err_o;
`endif

  mul_post #(.XLEN(XLEN), .STAGES(STAGES), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .issue_op_i    (issue_op_i),
    .issue_neg_i   (issue_neg_i),
    .issue_rd_i    (issue_rd_i),
    .pipe_ready_i  (pipe_ready_i),
    .pipe_acc_i    (pipe_acc_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_data_o     (wb_data_o),
    .wb_rd_o       (wb_rd_o)
`ifdef MUL_POST_CHECK_EN
    ,
    .err_o         (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Cell-chain emulation: results scheduled by the edge at which they are written.
  logic        sched_v   [64];
  logic [64:0] sched_acc [64];
  logic [36:0] exp_q [$];
  int          n = 0;
  int          stored = 0;
  int          mcred = DEPTH;
  logic        m_err = 1'b0;

  logic        s_iv, s_neg, s_wbr, s_fl, s_usex, s_force_pr;
  logic [1:0]  s_op;
  logic [4:0]  s_rd;
  logic [64:0] s_acc;
  logic [36:0] s_exp;
  logic        dut_acc;

  function automatic logic [36:0] ref_result(logic [1:0] op, logic neg, logic [4:0] rd, logic [64:0] acc);
    logic [63:0] p, r;
    p = acc[63:0];
    r = neg ? (64'd0 - p) : p;
    return {(op == 2'b00) ? r[31:0] : r[63:32], rd};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got=%h required=%h", nm, n, got, req);
    end
  endtask

  task automatic idle_vars();
    s_iv = 0; s_op = 0; s_neg = 0; s_rd = 0; s_acc = '0;
    s_fl = 0; s_usex = 0; s_exp = '0; s_force_pr = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
    exp_q.delete();
    stored = 0;
    mcred  = DEPTH;
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model across the edge.
  task automatic step();
    int   idx;
    logic acc, pop, wr;
    idx = n % 64;
    issue_valid_i = s_iv;
    issue_op_i    = s_op;
    issue_neg_i   = s_neg;
    issue_rd_i    = s_rd;
    flush_i       = s_fl;
    wb_ready_i    = s_wbr;
    pipe_ready_i  = sched_v[idx] | s_force_pr;
    pipe_acc_i    = sched_v[idx] ? sched_acc[idx] : {1'($urandom), 32'($urandom), 32'($urandom)};
    chk("issue_ready", 64'(issue_ready_o), 64'(mcred != 0));
    chk("wb_valid", 64'(wb_valid_o), 64'(stored != 0));
`ifdef MUL_POST_CHECK_EN
    chk("err", 64'(err_o), 64'(m_err));
`endif
    dut_acc = s_iv && issue_ready_o;
    if (s_force_pr) m_err = 1'b1;
    if (s_fl) begin
      clear_model();
    end else begin
      wr  = sched_v[idx];
      pop = (stored > 0) && s_wbr;
      acc = s_iv && (mcred > 0);
      sched_v[idx] = 1'b0;
      if (acc) begin
        sched_v[(n + STAGES) % 64]   = 1'b1;
        sched_acc[(n + STAGES) % 64] = s_acc;
        exp_q.push_back(s_usex ? s_exp : ref_result(s_op, s_neg, s_rd, s_acc));
      end
      stored = stored + int'(wr) - int'(pop);
      mcred  = mcred + int'(pop) - int'(acc);
    end
    @(posedge clk_i);
    #1;
    n++;
  endtask

  task automatic idle(input int cycles, input logic wbr);
    idle_vars();
    s_wbr = wbr;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic issue_dir(input logic [1:0] op, input logic neg, input logic [4:0] rd,
                           input logic [64:0] acc, input logic [31:0] expd);
    idle_vars();
    s_iv = 1; s_op = op; s_neg = neg; s_rd = rd; s_acc = acc;
    s_usex = 1; s_exp = {expd, rd};
    step();
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    issue_valid_i = 0; flush_i = 0; pipe_ready_i = 0;
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_wb_data", 64'(wb_data_o), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd_o), 64'd0);
`ifdef MUL_POST_CHECK_EN
    chk("rst_err", 64'(err_o), 64'd0);
`endif
    clear_model();
    m_err = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    n++;
  endtask

  // Monitor: every DUT pop is checked against the oldest expected result.
  always @(negedge clk_i) begin
    if (rst_ni && wb_valid_o && wb_ready_i && !flush_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got data=%h rd=%0d, required no output", wb_data_o, wb_rd_o);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wb_data_o, wb_rd_o} !== e)
          begin
            n_bad++;
            $display("FAIL wb_result: got data=%h rd=%0d, required data=%h rd=%0d",
                     wb_data_o, wb_rd_o, e[36:5], e[4:0]);
          end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    for (int i = 0; i < 64; i++) begin sched_v[i] = 1'b0; sched_acc[i] = '0; end
    rst_ni = 1'b0;
    issue_valid_i = 0; issue_op_i = 0; issue_neg_i = 0; issue_rd_i = 0;
    flush_i = 0; pipe_ready_i = 0; pipe_acc_i = '0; wb_ready_i = 0;
    idle_vars();
    s_wbr = 0;
    @(posedge clk_i);
    #1;
    chk("reset_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("reset_issue_ready", 64'(issue_ready_o), 64'd1);
    chk("reset_wb_data", 64'(wb_data_o), 64'd0);
    chk("reset_wb_rd", 64'(wb_rd_o), 64'd0);
`ifdef MUL_POST_CHECK_EN
    chk("reset_err", 64'(err_o), 64'd0);
`endif
    rst_ni = 1'b1;
    idle(2, 1'b1);

    // Directed result formatting cases.
    issue_dir(2'b00, 1'b1, 5'd7,  65'd15,                   32'hFFFF_FFF1);
    issue_dir(2'b11, 1'b0, 5'd12, 65'h0_FFFF_FFFE_0000_0001, 32'hFFFF_FFFE);
    issue_dir(2'b01, 1'b1, 5'd31, 65'h0_0000_0001_0000_0000, 32'hFFFF_FFFF);
    issue_dir(2'b01, 1'b0, 5'd3,  65'h1_0000_0000_0000_0001, 32'h0000_0000);
    idle(STAGES + 4, 1'b1);

    // Backpressure: six back-to-back issues into a stalled writeback.
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      idle_vars();
      s_iv = 1; s_op = 2'($urandom); s_neg = 1'($urandom); s_rd = 5'(i + 1);
      s_acc = {1'b0, 32'($urandom), 32'($urandom)};
      s_wbr = 0;
      step();
      if (dut_acc) accepted++;
    end
    chk("bp_accepted", 64'(accepted), 64'd4);
    idle(STAGES + 3, 1'b0);
    idle(DEPTH + 3, 1'b1);

    // Flush with one stored result and three in flight.
    idle_vars(); s_iv = 1; s_rd = 5'd9; s_acc = 65'd100; s_wbr = 0; step();
    idle(STAGES + 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle_vars(); s_iv = 1; s_rd = 5'(20 + i); s_acc = 65'(1000 + i); s_wbr = 0; step();
    end
    idle(3, 1'b0);
    idle_vars(); s_fl = 1; s_iv = 1; s_wbr = 1; step();
    idle(STAGES + 6, 1'b1);

`ifdef MUL_POST_CHECK_EN
    // Spurious pipe_ready with nothing in flight must raise a sticky error.
    idle_vars(); s_force_pr = 1; s_wbr = 1; step();
    idle(5, 1'b1);
    do_reset();
    idle(2, 1'b1);
`endif

    // Randomized traffic with occasional flushes and one asynchronous reset.
    for (int i = 0; i < 800; i++) begin
      idle_vars();
      s_iv  = ($urandom_range(0, 9) < 7);
      s_op  = 2'($urandom);
      s_neg = 1'($urandom);
      s_rd  = 5'($urandom);
      s_acc = {1'($urandom), 32'($urandom), 32'($urandom)};
      s_wbr = ($urandom_range(0, 9) < 6);
      s_fl  = ($urandom_range(0, 99) == 0);
      step();
      if (i == 400) begin
        do_reset();
      end
    end

    // Drain with a bounded budget.
    idle_vars();
    s_wbr = 1;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && stored == 0) break;
      step();
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
